// File: rtl/game_2048_ps2_input_pkg.sv
// Shared constants and decode helpers for the 2048 PS/2 input front-end.
// Latency: none (package only: constants, types and pure functions).
// Backpressure: n/a.
package game_2048_pkg;

  // Move directions as understood by the board core
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Scan-code set 2 prefixes and key codes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // A decoded move candidate
  typedef struct packed {
    logic       vld;
    logic [1:0] dir;
  } move_t;

  // Extended (E0-prefixed) arrow keys
  function automatic move_t map_arrow(input logic [7:0] code);
    move_t m;
    m.vld = 1'b1;
    m.dir = DIR_UP;
    case (code)
      SC_UP:    m.dir = DIR_UP;
      SC_LEFT:  m.dir = DIR_LEFT;
      SC_DOWN:  m.dir = DIR_DOWN;
      SC_RIGHT: m.dir = DIR_RIGHT;
      default:  m.vld = 1'b0;
    endcase
    return m;
  endfunction

  // Plain (non-extended) W/A/S/D keys
  function automatic move_t map_wasd(input logic [7:0] code);
    move_t m;
    m.vld = 1'b1;
    m.dir = DIR_UP;
    case (code)
      SC_W:    m.dir = DIR_UP;
      SC_A:    m.dir = DIR_LEFT;
      SC_S:    m.dir = DIR_DOWN;
      SC_D:    m.dir = DIR_RIGHT;
      default: m.vld = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/game_2048_ps2_input_if.sv
// Pin-side and core-side signals of the 2048 PS/2 input front-end.
// Latency: none (wiring only).
// Backpressure: none; move requests are fire-and-forget pulses.
interface game_2048_ps2_input_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       frame_err;

  // Keyboard/core side: drives the PS/2 pins, consumes move requests
  modport master (
    output ps2_clk, ps2_data,
    input  move_valid, move_dir, frame_err
  );

  // Front-end side
  modport slave (
    input  ps2_clk, ps2_data,
    output move_valid, move_dir, frame_err
  );
endinterface

// File: rtl/game_2048_ps2_input_frame_rx.sv
// PS/2 frame receiver: 2-FF synchronizers, falling-edge detect, 11-bit frame FSM, timeout.
// Latency: byte_strobe_o/frame_err_o registered 2 clk after the edge that first samples ps2_clk low.
// Backpressure: none; the keyboard cannot be stalled, bytes are strobed for one cycle.
module ps2_frame_rx
  import game_2048_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_strobe_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  logic          clk_s1_q, clk_s2_q, clk_dly_q;
  logic          dat_s1_q, dat_s2_q;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    data_q, data_d;
  logic          err_q, err_d;
  logic          fall;
  logic          timeout;

  // Synchronize both pins; lines idle high so reset them to 1 to avoid a fake edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_dly_q <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      clk_dly_q <= clk_s2_q;
      dat_s1_q  <= ps2_data_i;
      dat_s2_q  <= dat_s1_q;
    end
  end

  assign fall    = clk_dly_q & ~clk_s2_q;
  assign timeout = (state_q != RX_IDLE) && !fall &&
                   (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Frame FSM next state: one step per falling edge, timeout abandons a partial frame
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;

    if (state_q == RX_IDLE || fall) idle_cnt_d = '0;
    else                            idle_cnt_d = idle_cnt_q + CW'(1);

    if (timeout) begin
      state_d    = RX_IDLE;
      err_d      = 1'b1;
      idle_cnt_d = '0;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          // A high data line here is line noise, not a start bit; ignore silently
          if (!dat_s2_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = ^{dat_s2_q, shift_q};
          state_d  = RX_STOP;
        end
        default: begin
          if (dat_s2_q && par_ok_q) begin
            strobe_d = 1'b1;
            data_d   = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  // Frame FSM state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_ok_q   <= 1'b0;
      idle_cnt_q <= '0;
      strobe_q   <= 1'b0;
      data_q     <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      idle_cnt_q <= idle_cnt_d;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign byte_strobe_o = strobe_q;
  assign byte_data_o   = data_q;
  assign frame_err_o   = err_q;

endmodule

// File: rtl/game_2048_ps2_input.sv
// 2048 input front-end: PS/2 bytes -> arrow-key move pulses; optional W/A/S/D via GAME_2048_PS2_WASD_EN.
// Latency: move_valid registered 1 clk after byte_strobe (3 clk after stop bit first sampled low).
// Backpressure: none; moves inside the holdoff window are dropped, never queued.
module game_2048_ps2_input
  import game_2048_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int HOLDOFF_CYCLES = 4     // keep >= 3: the board core needs 3 cycles per move
) (
  input  logic                  clk,
  input  logic                  reset_n,
  game_2048_ps2_input_if.slave  ps2
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  logic          rx_strobe;
  logic [7:0]    rx_data;
  logic          rx_err;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  move_t         dec;
  logic          move_valid_q, move_valid_d;
  logic [1:0]    move_dir_q, move_dir_d;
  logic [HW-1:0] hold_q, hold_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk           (clk),
    .reset_n       (reset_n),
    .ps2_clk_i     (ps2.ps2_clk),
    .ps2_data_i    (ps2.ps2_data),
    .byte_strobe_o (rx_strobe),
    .byte_data_o   (rx_data),
    .frame_err_o   (rx_err)
  );

  // Scan decoder: track E0/F0 prefixes, turn the final byte of a sequence into a move
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    dec   = '0;
    if (rx_err) begin
      // A corrupted byte may have been a prefix or the key itself; start over
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_strobe) begin
      if (rx_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_data == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          if (ext_q) begin
            dec = map_arrow(rx_data);
          end else begin
`ifdef GAME_2048_PS2_WASD_EN
            dec = map_wasd(rx_data);
`else
            dec = '0;
`endif
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Holdoff: accept a move only when the registered counter is already zero
  always_comb begin
    move_valid_d = 1'b0;
    move_dir_d   = move_dir_q;
    hold_d       = (hold_q != '0) ? hold_q - HW'(1) : '0;
    if (dec.vld && hold_q == '0) begin
      move_valid_d = 1'b1;
      move_dir_d   = dec.dir;
      hold_d       = HW'(HOLDOFF_CYCLES);
    end
  end

  // Decoder flags, holdoff counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      move_valid_q <= 1'b0;
      move_dir_q   <= DIR_UP;
      hold_q       <= '0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      move_valid_q <= move_valid_d;
      move_dir_q   <= move_dir_d;
      hold_q       <= hold_d;
    end
  end

  assign ps2.move_valid = move_valid_q;
  assign ps2.move_dir   = move_dir_q;
  assign ps2.frame_err  = rx_err;

endmodule

// File: tb/tb_game_2048_ps2_input.sv
// Bench for game_2048_ps2_input: bit-banged PS/2 frames, move scoreboard, error/latency checks.
// Runs with a scaled PS/2 clock and short timeout/holdoff so the whole run stays small.
// Moves are checked in order against an expected-direction queue as they appear.
module tb_game_2048_ps2_input;

  localparam int T    = 100;  // TIMEOUT_CYCLES
  localparam int HOLD = 44;   // HOLDOFF_CYCLES, chosen to hit the 1->0 boundary in test_holdoff
  localparam int H    = 10;   // PS/2 half-period in clk cycles

  logic clk;
  logic reset_n;
  game_2048_ps2_input_if ps2_if ();

  game_2048_ps2_input #(
    .TIMEOUT_CYCLES (T),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2     (ps2_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         mv_cnt = 0;
  int         err_cnt = 0;
  int         last_mv_cyc = 0;
  int         last_err_cyc = 0;
  int         last_fall_cyc = 0;
  logic [1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every move pulse must match the oldest expected direction
  always @(negedge clk) begin
    logic [1:0] e;
    if (reset_n && ps2_if.move_valid === 1'b1) begin
      mv_cnt++;
      last_mv_cyc = cyc;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL move_unexpected: got dir %0d, wanted no move", ps2_if.move_dir);
      end else begin
        e = exp_q.pop_front();
        if (ps2_if.move_dir !== e)
          $display("FAIL move_dir: got %0d want %0d", ps2_if.move_dir, e);
        else
          pass_cnt++;
      end
    end
    if (ps2_if.frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  task automatic send_bit(input logic b, input int h);
    ps2_if.ps2_data = b;
    repeat (h) @(negedge clk);
    ps2_if.ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (h) @(negedge clk);
    ps2_if.ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int h, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, h);
    for (int i = 0; i < 8; i++) send_bit(b[i], h);
    send_bit(par, h);
    send_bit(1'b1, h);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    chk_cnt++;
    if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ps2_if.ps2_clk  = 1'b1;
    ps2_if.ps2_data = 1'b1;
    idle(5);
    chk_cnt++;
    if ({ps2_if.move_valid, ps2_if.move_dir, ps2_if.frame_err} !== 4'b0)
      $display("FAIL reset_outputs: got %b want 0000",
               {ps2_if.move_valid, ps2_if.move_dir, ps2_if.frame_err});
    else pass_cnt++;
    reset_n = 1'b1;
    idle(20);
    chk_cnt++;
    if ({ps2_if.move_valid, ps2_if.frame_err} !== 2'b0 || mv_cnt != 0 || err_cnt != 0)
      $display("FAIL post_reset_quiet: moves %0d errs %0d want 0 0", mv_cnt, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_arrow_up;
    int m0, e0;
    m0 = mv_cnt; e0 = err_cnt;
    exp_q.push_back(2'd0);
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h75, H, 1'b0);
    idle(20);
    check_int("up_move_count", mv_cnt - m0, 1);
    // ps2_clk is driven between edges; the first sampling edge is one cycle later,
    // move_valid then follows 3 cycles after that edge.
    check_int("up_latency", last_mv_cyc - last_fall_cyc, 4);
    check_int("up_no_err", err_cnt - e0, 0);
  endtask

  task automatic test_break;
    int m0;
    m0 = mv_cnt;
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'hF0, H, 1'b0);
    send_byte(8'h6B, H, 1'b0);
    send_byte(8'h75, H, 1'b0);  // no E0: ext must be clear, keypad 8 is not a move
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h70, H, 1'b0);  // unmapped extended code
    idle(20);
    check_int("break_no_move", mv_cnt - m0, 0);
    exp_q.push_back(2'd0);      // brk must be clear too
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h75, H, 1'b0);
    idle(20);
    check_int("after_break_move", mv_cnt - m0, 1);
  endtask

  task automatic test_parity;
    int m0, e0;
    m0 = mv_cnt; e0 = err_cnt;
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h72, H, 1'b1);
    idle(20);
    check_int("parity_err", err_cnt - e0, 1);
    check_int("parity_no_move", mv_cnt - m0, 0);
    exp_q.push_back(2'd3);
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h74, H, 1'b0);
    idle(30);
    check_int("parity_recover_move", mv_cnt - m0, 1);
    chk_cnt++;
    if (ps2_if.move_dir !== 2'd3) $display("FAIL dir_hold: got %0d want 3", ps2_if.move_dir);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int m0, e0;
    m0 = mv_cnt; e0 = err_cnt;
    send_bit(1'b0, H);
    for (int i = 0; i < 4; i++) send_bit(i[0], H);
    idle(T + 30);
    check_int("timeout_err", err_cnt - e0, 1);
    check_int("timeout_cycles", last_err_cyc - last_fall_cyc, T + 3);
    exp_q.push_back(2'd1);
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h6B, H, 1'b0);
    idle(20);
    check_int("timeout_recover_move", mv_cnt - m0, 1);
    check_int("timeout_single_err", err_cnt - e0, 1);
  endtask

  task automatic test_back_to_back;
    int m0;
    m0 = mv_cnt;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h72, H, 1'b0);
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h72, H, 1'b0);
    idle(20);
    check_int("typematic_moves", mv_cnt - m0, 2);
  endtask

  task automatic test_holdoff;
    int m0;
    m0 = mv_cnt;
    // Back-to-back fast frames: second decode lands while the counter is still 1
    exp_q.push_back(2'd0);
    send_byte(8'hE0, 1, 1'b0);
    send_byte(8'h75, 1, 1'b0);
    send_byte(8'hE0, 1, 1'b0);
    send_byte(8'h6B, 1, 1'b0);
    idle(HOLD + 20);
    check_int("holdoff_drop", mv_cnt - m0, 1);
    // One extra cycle between the pairs: the counter is 0 and the move is accepted
    m0 = mv_cnt;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    send_byte(8'hE0, 1, 1'b0);
    send_byte(8'h75, 1, 1'b0);
    idle(1);
    send_byte(8'hE0, 1, 1'b0);
    send_byte(8'h6B, 1, 1'b0);
    idle(HOLD + 20);
    check_int("holdoff_accept", mv_cnt - m0, 2);
  endtask

  task automatic test_wasd;
    int m0, n;
    m0 = mv_cnt;
    n  = 0;
`ifdef GAME_2048_PS2_WASD_EN
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    n = 2;
`endif
    send_byte(8'h1D, H, 1'b0);
    send_byte(8'h23, H, 1'b0);
    idle(20);
    check_int("wasd_moves", mv_cnt - m0, n);
  endtask

  task automatic test_mid_reset;
    int m0, e0;
    send_bit(1'b0, H);
    for (int i = 0; i < 3; i++) send_bit(1'b1, H);
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    m0 = mv_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit(i[0], H);
    send_bit(1'b0, H);
    send_bit(1'b1, H);
    idle(T + 30);
    chk_cnt++;
    if (err_cnt - e0 > 1) $display("FAIL mid_reset_errs: got %0d want <= 1", err_cnt - e0);
    else pass_cnt++;
    exp_q.push_back(2'd0);
    send_byte(8'hE0, H, 1'b0);
    send_byte(8'h75, H, 1'b0);
    idle(20);
    check_int("mid_reset_recover", mv_cnt - m0, 1);
  endtask

  initial begin
    test_reset();
    test_arrow_up();
    test_break();
    test_parity();
    test_timeout();
    test_back_to_back();
    test_holdoff();
    test_wasd();
    test_mid_reset();
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
